slave_serial_responder: RTL and testbench
=========================================

SLAVE_SERIAL_RESPONDER -- requirements
Module: slave_serial_responder

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 12, the number of serial address bits and the log2 of the memory depth.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the bits per data word.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port mvalid  input  1  master frame valid; qualifies swdata every cycle of a frame.
REQ-006 The block SHALL have port smode  input  1  transaction type, sampled on the first frame cycle only; 1=write, 0=read.
REQ-007 The block SHALL have port swdata  input  1  serial address then write-data bit, LSB first.
REQ-008 The block SHALL have port srdata  output  1  serial read-data bit, LSB first.
REQ-009 The block SHALL have port svalid  output  1  high while srdata carries valid read data.
REQ-010 The block SHALL have port sready  output  1  high only in IDLE; slave accepts a new frame.

Function
REQ-011 The block SHALL contain 2^MEM_ADDR_WIDTH x DATA_WIDTH storage; memory is not cleared by reset.
REQ-012 The FSM SHALL have the states IDLE, ADDR, WDATA, WRITE, RLAT and RDATA.
REQ-013 In IDLE, the edge E0 with mvalid=1 SHALL capture smode and swdata as addr[0], load the bit counter with 1 and go to ADDR.
REQ-014 In IDLE with mvalid=0, the block SHALL stay in IDLE.
REQ-015 In ADDR, each edge with mvalid=1 SHALL shift swdata into addr[count] and increment count.
REQ-016 At edge E(MEM_ADDR_WIDTH-1), the FSM SHALL go to WDATA if smode=1 or to RLAT if smode=0, and clear count.
REQ-017 In WDATA, each edge with mvalid=1 SHALL shift swdata into data[count].
REQ-018 After DATA_WIDTH bits (edge E19 at defaults), the FSM SHALL go to WRITE.
REQ-019 WRITE SHALL last 1 cycle: mem[addr] <= data on the next edge (E20), then go to IDLE.
REQ-020 RLAT SHALL last 1 cycle: load the shift register with mem[addr] on edge E12 at defaults, then go to RDATA.
REQ-021 RDATA SHALL hold svalid=1 for exactly DATA_WIDTH cycles, with srdata = shift[0] and the shift register moving right each edge.
REQ-022 After the last read bit (edge E20 at defaults), the FSM SHALL go to IDLE.
REQ-023 When svalid=0, srdata SHALL be 0.
REQ-024 sready SHALL be registered: 0 from the cycle after E0 until the FSM re-enters IDLE.
REQ-025 Write turnaround SHALL be sready high after edge E(MEM_ADDR_WIDTH+DATA_WIDTH), i.e. E20 at defaults.
REQ-026 Read turnaround SHALL be: first svalid after E(MEM_ADDR_WIDTH), sready high after E(MEM_ADDR_WIDTH+DATA_WIDTH).
REQ-027 mvalid=0 in ADDR or WDATA SHALL abort the frame: go to IDLE on that edge, with no memory write and no svalid.
REQ-028 mvalid, smode and swdata SHALL be ignored in WRITE, RLAT and RDATA; the frame length is fixed.
REQ-029 smode changes after E0 SHALL have no effect on the current frame.
REQ-030 A new frame SHALL be accepted on the first edge with the FSM in IDLE and mvalid=1; back-to-back frames need no idle gap beyond the IDLE cycle.
REQ-031 Address MEM_ADDR_WIDTH-bit all-ones (0xFFF) SHALL be valid; there SHALL be no wrap or overflow logic on the address.

Reset
REQ-032 While rstn=0, the block SHALL force state=IDLE, count=0, addr=0, data=0, shift=0, sready=1, svalid=0 and srdata=0, asynchronously.
REQ-033 Reset asserted mid-frame SHALL leave memory unchanged; a WRITE cut by reset SHALL NOT commit.
REQ-034 The first frame SHALL be accepted on the first rising edge after rstn deasserts.

Verification
REQ-035 The bench SHALL cover a write: addr 0x0A5, data 0x3C -> sready=0 for 20 cycles, then mem[0x0A5]=0x3C.
REQ-036 The bench SHALL cover a read after that write: addr 0x0A5 -> after 12 addr bits plus 1 latency cycle, svalid=1 for 8 cycles, srdata sequence 0,0,1,1,1,1,0,0, then sready=1.
REQ-037 The bench SHALL cover an abort: write to 0x0A5 with mvalid dropped after 3 data bits -> IDLE next edge, and a readback still returns 0x3C.
REQ-038 The bench SHALL cover a boundary write/read: write 0xFF to 0xFFF and 0x01 to 0x000 -> reads return 0xFF and 0x01 respectively.
REQ-039 The bench SHALL cover reset mid-read: rstn=0 during RDATA bit 4 -> svalid=0 and srdata=0 immediately, sready=1, and the next read of the same address returns the full word.
REQ-040 The bench SHALL cover back-to-back frames: a write, then a read with mvalid raised in the IDLE cycle -> both complete with correct data and no lost bit.

Source files
------------

// File: rtl/slave_serial_responder_if.sv
// Serial bus between a master and slave_serial_responder.
// The master drives the frame (mvalid/smode/swdata); the slave returns
// read data (srdata/svalid) and its ready status (sready).
interface slave_serial_responder_if;
  logic mvalid;
  logic smode;
  logic swdata;
  logic srdata;
  logic svalid;
  logic sready;

  modport master (
    output mvalid, smode, swdata,
    input  srdata, svalid, sready
  );

  modport slave (
    input  mvalid, smode, swdata,
    output srdata, svalid, sready
  );
endinterface

// File: rtl/slave_serial_responder.sv
// Serial-access memory slave.
// A frame is MEM_ADDR_WIDTH address bits (LSB first) followed, for writes,
// by DATA_WIDTH data bits. A read returns DATA_WIDTH bits LSB first after
// one latency cycle. Dropping mvalid mid-frame aborts without side effects.
module slave_serial_responder #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  slave_serial_responder_if.slave bus
);

  localparam int MAX_W = (MEM_ADDR_WIDTH > DATA_WIDTH) ? MEM_ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(MEM_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RLAT,
    RDATA
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CNT_W-1:0]          count;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH-1:0]     shift;
  logic                      mode;
  logic                      sready_q;
  logic                      svalid_q;
  logic                      addr_done;
  logic                      data_done;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  assign addr_done = (count == ADDR_LAST);
  assign data_done = (count == DATA_LAST);

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: abort on mvalid=0 while collecting bits; fixed-length
  // WRITE/RLAT/RDATA phases ignore the bus.
  // NOTE: state_next gets a default before the case so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.mvalid) state_next = ADDR;
      ADDR: begin
        if (!bus.mvalid)    state_next = IDLE;
        else if (addr_done) state_next = mode ? WDATA : RLAT;
      end
      WDATA: begin
        if (!bus.mvalid)    state_next = IDLE;
        else if (data_done) state_next = WRITE;
      end
      WRITE: state_next = IDLE;
      RLAT:  state_next = RDATA;
      RDATA: if (data_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: bit counter, address/data deserialisers, read shifter and the
  // registered handshake outputs. Bits enter at the MSB and move right, so
  // after a full field the first (LSB-first) bit sits at index 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      addr     <= '0;
      data     <= '0;
      shift    <= '0;
      mode     <= 1'b0;
      sready_q <= 1'b1;
      svalid_q <= 1'b0;
    end else begin
      sready_q <= (state_next == IDLE);
      svalid_q <= (state_next == RDATA);
      unique case (state)
        IDLE: begin
          if (bus.mvalid) begin
            mode  <= bus.smode;
            addr  <= {bus.swdata, addr[MEM_ADDR_WIDTH-1:1]};
            count <= CNT_W'(1);
          end
        end
        ADDR: begin
          if (bus.mvalid) begin
            addr  <= {bus.swdata, addr[MEM_ADDR_WIDTH-1:1]};
            count <= addr_done ? '0 : count + CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        WDATA: begin
          if (bus.mvalid) begin
            data  <= {bus.swdata, data[DATA_WIDTH-1:1]};
            count <= data_done ? '0 : count + CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        WRITE: count <= '0;
        RLAT: begin
          shift <= mem[addr];
          count <= '0;
        end
        RDATA: begin
          shift <= {1'b0, shift[DATA_WIDTH-1:1]};
          count <= data_done ? '0 : count + CNT_W'(1);
        end
        default: count <= '0;
      endcase
    end
  end

  // Storage write port; commits only from the WRITE state, which reset
  // leaves asynchronously, so an interrupted write never lands.
  // NOTE: the memory array has no reset; contents survive rstn and the
  // array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[addr] <= data;
  end

  assign bus.sready = sready_q;
  assign bus.svalid = svalid_q;
  assign bus.srdata = svalid_q & shift[0];

endmodule

// File: tb/tb_slave_serial_responder.sv
// Self-checking bench for slave_serial_responder: directed scenarios
// followed by randomized frames, checked through a read-data scoreboard
// against an associative-array memory model.
module tb_slave_serial_responder;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  slave_serial_responder_if bus ();

  slave_serial_responder #(
    .MEM_ADDR_WIDTH(AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model_mem [int];
  logic [AW-1:0] written [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus values the DUT must ignore in the current phase.
  task automatic junk_inputs();
    bus.mvalid = 1'($urandom_range(0, 1));
    bus.smode  = 1'($urandom_range(0, 1));
    bus.swdata = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mvalid = 1'b0;
      bus.smode  = 1'($urandom_range(0, 1));
      bus.swdata = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("idle_sready", bus.sready, 1);
    end
  endtask

  // One frame. abort_at: frame bit index whose edge sees mvalid=0 (-1 none).
  // rst_bit: read bit during which rstn is pulsed (-1 none).
  task automatic frame(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int abort_at, input int rst_bit);
    int nbits;
    nbits = wr ? AW + DW : AW;
    if (!wr && abort_at < 0) exp_q.push_back(model_mem[int'(a)]);
    for (int k = 0; k < nbits; k++) begin
      bus.mvalid = (k != abort_at);
      bus.smode  = (k == 0) ? wr : 1'($urandom_range(0, 1));
      bus.swdata = (k < AW) ? a[k] : d[k-AW];
      @(posedge clk); #1;
      if (k == abort_at) begin
        check("abort_to_idle", bus.sready, 1);
        check("abort_no_svalid", bus.svalid, 0);
        bus.mvalid = 1'b0;
        return;
      end
      check("busy_sready", bus.sready, 0);
    end
    if (wr) begin
      junk_inputs();
      @(posedge clk); #1;
      check("write_done_sready", bus.sready, 1);
      if (!model_mem.exists(int'(a))) written.push_back(a);
      model_mem[int'(a)] = d;
    end else begin
      check("rlat_svalid", bus.svalid, 0);
      junk_inputs();
      @(posedge clk); #1;
      for (int b = 0; b < DW; b++) begin
        if (b == rst_bit) begin
          rstn = 1'b0;
          bus.mvalid = 1'b0;
          #1;
          check("rst_svalid", bus.svalid, 0);
          check("rst_srdata", bus.srdata, 0);
          check("rst_sready", bus.sready, 1);
          repeat (2) @(negedge clk);
          rstn = 1'b1;
          return;
        end
        check("read_svalid", bus.svalid, 1);
        check("read_sready", bus.sready, 0);
        junk_inputs();
        @(posedge clk); #1;
      end
      check("read_done_svalid", bus.svalid, 0);
      check("read_done_sready", bus.sready, 1);
    end
    bus.mvalid = 1'b0;
  endtask

  // Monitor: assembles each svalid burst into a word and compares it with
  // the oldest outstanding expectation. A reset cancels a burst in flight.
  int            mon_nb   = 0;
  logic [DW-1:0] mon_word = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      if (mon_nb > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
      mon_nb   = 0;
      mon_word = '0;
    end else if (bus.svalid) begin
      if (mon_nb < DW) mon_word[mon_nb] = bus.srdata;
      mon_nb++;
    end else begin
      check("srdata_quiet", bus.srdata, 0);
      if (mon_nb > 0) begin
        check("read_len", mon_nb, DW);
        check("sb_has_entry", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("read_data", mon_word, exp_q.pop_front());
        mon_nb   = 0;
        mon_word = '0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    bit            reset_seen_idle;
    bus.mvalid = 1'b0;
    bus.smode  = 1'b0;
    bus.swdata = 1'b0;
    rstn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sready", bus.sready, 1);
    check("reset_svalid", bus.svalid, 0);
    check("reset_srdata", bus.srdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // First frame right on the first edge after reset release.
    frame(1, 12'h0A5, 8'h3C, -1, -1);
    frame(0, 12'h0A5, '0, -1, -1);
    idle_cycles(1);

    // Abort after 3 data bits, then confirm the old word survives.
    frame(1, 12'h0A5, 8'hC3, AW + 3, -1);
    frame(0, 12'h0A5, '0, -1, -1);

    // Address boundaries.
    frame(1, 12'hFFF, 8'hFF, -1, -1);
    frame(1, 12'h000, 8'h01, -1, -1);
    frame(0, 12'hFFF, '0, -1, -1);
    frame(0, 12'h000, '0, -1, -1);

    // Reset during read bit 4, then a full read of the same address.
    frame(0, 12'h0A5, '0, -1, 4);
    frame(0, 12'h0A5, '0, -1, -1);

    // Back-to-back write then read, no gap beyond the IDLE cycle.
    frame(1, 12'h123, 8'h5A, -1, -1);
    frame(0, 12'h123, '0, -1, -1);
    frame(0, 12'hFFF, '0, -1, -1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      ra = written[$urandom_range(0, written.size() - 1)];
      if (op <= 3)      frame(1, AW'($urandom), DW'($urandom), -1, -1);
      else if (op <= 7) frame(0, ra, '0, -1, -1);
      else if (op == 8) frame(1, ra, DW'($urandom), int'($urandom_range(1, AW + DW - 1)), -1);
      else              frame(0, ra, '0, int'($urandom_range(1, AW - 1)), -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Bounded wait for the slave to settle in IDLE.
    reset_seen_idle = 1'b0;
    for (int i = 0; i < 50 && !reset_seen_idle; i++) begin
      @(posedge clk); #1;
      reset_seen_idle = bus.sready;
    end
    check("final_idle", reset_seen_idle, 1);
    idle_cycles(2);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
